// File: rtl/sorted_cam_topk_reader.sv
// Read-side companion to the sorted address/count CAM. On a host query it
// snapshots the descending-sorted table once the table is quiet, then streams
// the top-K hottest (addr, cnt) entries over a valid/ready interface, stopping
// early at the first empty slot or the first entry below the count threshold.
module sorted_cam_topk_reader #(
  parameter int NUM_ENTRY  = 25,
  parameter int INDEX_SIZE = 5,
  parameter int ADDR_SIZE  = 22,
  parameter int CNT_SIZE   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          query_valid,
  output logic                          query_ready,
  input  logic [INDEX_SIZE-1:0]         query_top_k,
  input  logic [CNT_SIZE-1:0]           query_thresh,
  input  logic                          tbl_busy,
  input  logic [NUM_ENTRY*ADDR_SIZE-1:0] tbl_addr_flat,
  input  logic [NUM_ENTRY*CNT_SIZE-1:0]  tbl_cnt_flat,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDR_SIZE-1:0]          out_addr,
  output logic [CNT_SIZE-1:0]           out_cnt,
  output logic [INDEX_SIZE-1:0]         out_rank,
  output logic                          out_last,
  output logic                          done_valid,
  output logic [INDEX_SIZE-1:0]         done_count,
  output logic                          busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [INDEX_SIZE-1:0] NUM_ENTRY_I = INDEX_SIZE'(NUM_ENTRY);

  logic [1:0]            state;
  logic [INDEX_SIZE-1:0] k_eff;
  logic [CNT_SIZE-1:0]   thresh;
  logic [INDEX_SIZE-1:0] idx;
  logic [INDEX_SIZE-1:0] sent;

  logic [ADDR_SIZE-1:0]  snap_addr [NUM_ENTRY];
  logic [CNT_SIZE-1:0]   snap_cnt  [NUM_ENTRY];

  // One extra always-zero bit so that "entry after the last slot" reads as ineligible.
  logic [NUM_ENTRY:0]    elig;
  logic                  cur_elig;
  logic                  nxt_elig;
  logic [INDEX_SIZE-1:0] idx_nxt;
  logic [INDEX_SIZE-1:0] rd_idx;
  logic [INDEX_SIZE-1:0] k_req;

  // Requested depth, with 0 or anything past the table meaning "whole table".
  assign k_req = (query_top_k == '0 || query_top_k > NUM_ENTRY_I) ? NUM_ENTRY_I : query_top_k;

  // Per-slot eligibility of the snapshot against the latched query.
  always_comb begin
    // NOTE: default every bit first so no path leaves elig unassigned and a latch is never inferred.
    elig = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      elig[i] = (snap_cnt[i] != '0) && (snap_cnt[i] >= thresh) && (INDEX_SIZE'(i) < k_eff);
    end
  end

  assign idx_nxt  = idx + 1'b1;
  assign cur_elig = (idx <= NUM_ENTRY_I) ? elig[idx] : 1'b0;
  assign nxt_elig = (idx_nxt <= NUM_ENTRY_I) ? elig[idx_nxt] : 1'b0;
  assign rd_idx   = (idx < NUM_ENTRY_I) ? idx : '0;

  // Beat fields come straight from registered state, so they hold while stalled.
  assign out_valid   = (state == S_STREAM) && cur_elig;
  assign out_addr    = out_valid ? snap_addr[rd_idx] : '0;
  assign out_cnt     = out_valid ? snap_cnt[rd_idx]  : '0;
  assign out_rank    = out_valid ? idx : '0;
  assign out_last    = out_valid && !nxt_elig;
  assign query_ready = (state == S_IDLE);
  assign done_valid  = (state == S_DONE);
  assign done_count  = (state == S_DONE) ? sent : '0;
  assign busy        = (state != S_IDLE);

  // Control FSM: query latch, wait for a quiet table, stream, one-cycle done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      k_eff  <= '0;
      thresh <= '0;
      idx    <= '0;
      sent   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge, independent of statement order.
      case (state)
        S_IDLE: begin
          if (query_valid) begin
            k_eff  <= k_req;
            thresh <= query_thresh;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!tbl_busy) begin
            idx   <= '0;
            sent  <= '0;
            state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (!cur_elig) begin
            state <= S_DONE;
          end else if (out_ready) begin
            idx  <= idx_nxt;
            sent <= sent + 1'b1;
            if (!nxt_elig) state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Snapshot capture: the whole table is copied in the cycle WAIT sees a quiet table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the snapshot array is reset explicitly so a fresh report can never see stale entries.
      for (int i = 0; i < NUM_ENTRY; i++) begin
        snap_addr[i] <= '0;
        snap_cnt[i]  <= '0;
      end
    end else if (state == S_WAIT && !tbl_busy) begin
      for (int i = 0; i < NUM_ENTRY; i++) begin
        snap_addr[i] <= tbl_addr_flat[i*ADDR_SIZE +: ADDR_SIZE];
        snap_cnt[i]  <= tbl_cnt_flat[i*CNT_SIZE +: CNT_SIZE];
      end
    end
  end

endmodule

// File: tb/tb_sorted_cam_topk_reader.sv
// Directed bench for sorted_cam_topk_reader: table-driven query vectors
// against a fixed descending table, plus hand sequences for reset mid-stream.
module tb_sorted_cam_topk_reader;

  localparam int NE = 25;
  localparam int IS = 5;
  localparam int AS = 22;
  localparam int CS = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              query_valid = 1'b0;
  logic              query_ready;
  logic [IS-1:0]     query_top_k = '0;
  logic [CS-1:0]     query_thresh = '0;
  logic              tbl_busy = 1'b0;
  logic [NE*AS-1:0]  tbl_addr_flat = '0;
  logic [NE*CS-1:0]  tbl_cnt_flat = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [AS-1:0]     out_addr;
  logic [CS-1:0]     out_cnt;
  logic [IS-1:0]     out_rank;
  logic              out_last;
  logic              done_valid;
  logic [IS-1:0]     done_count;
  logic              busy;

  int total  = 0;
  int passed = 0;

  sorted_cam_topk_reader #(
    .NUM_ENTRY(NE), .INDEX_SIZE(IS), .ADDR_SIZE(AS), .CNT_SIZE(CS)
  ) dut (
    .clk(clk), .rst(rst),
    .query_valid(query_valid), .query_ready(query_ready),
    .query_top_k(query_top_k), .query_thresh(query_thresh),
    .tbl_busy(tbl_busy), .tbl_addr_flat(tbl_addr_flat), .tbl_cnt_flat(tbl_cnt_flat),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_cnt(out_cnt), .out_rank(out_rank), .out_last(out_last),
    .done_valid(done_valid), .done_count(done_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Modes: 0 plain, 1 out_ready pattern 1,0,0,1, 2 tbl_busy held after query, 3 table rewritten mid-stream.
  typedef struct {
    logic [IS-1:0] k;
    logic [CS-1:0] th;
    int            n;
    int            mode;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference table: cnt 100,90,..,10 then zeros; alt fills every slot with 7 at different addresses.
  task automatic load_table(input bit alt);
    for (int i = 0; i < NE; i++) begin
      tbl_addr_flat[i*AS +: AS] = alt ? AS'(22'h3F0000 + i) : AS'(22'h001000 + i);
      tbl_cnt_flat[i*CS +: CS]  = alt ? 32'd7 : ((i < 10) ? CS'(100 - 10*i) : 32'd0);
    end
  endtask

  task automatic run_query(input logic [IS-1:0] k, input logic [CS-1:0] th, input int exp_n, input int mode);
    int j;
    int c;
    bit fin;
    bit first;
    logic [3:0] pat;
    pat = 4'b1001;
    j = 0; c = 0; fin = 0; first = 1;
    load_table(0);
    @(negedge clk);
    check("query_ready idle", query_ready, 1);
    query_top_k  = k;
    query_thresh = th;
    query_valid  = 1'b1;
    out_ready    = 1'b1;
    if (mode == 2) begin
      tbl_busy = 1'b1;
      load_table(1);
    end
    @(negedge clk);
    c = 1;
    query_valid = 1'b0;
    check("query_ready wait", query_ready, 0);
    check("busy wait", busy, 1);
    if (mode == 2) begin
      for (int t = 0; t < 3; t++) begin
        @(negedge clk);
        c++;
        check("no stream while tbl_busy", out_valid, 0);
      end
      tbl_busy = 1'b0;
      load_table(0);
      c = 1;
    end
    for (int t = 0; t < 80 && !fin; t++) begin
      @(negedge clk);
      c++;
      if (mode == 1) out_ready = pat[t % 4];
      if (out_valid) begin
        if (first && mode == 0) check("first beat latency", c, 2);
        first = 0;
        if (j >= exp_n) begin
          check("extra beat", 0, 1);
        end else begin
          check("beat cnt",  out_cnt,  64'(100 - 10*j));
          check("beat addr", out_addr, 64'(22'h001000 + j));
          check("beat rank", out_rank, 64'(j));
          check("beat last", out_last, (j == exp_n - 1) ? 1 : 0);
        end
        if (mode == 3 && j == 0) load_table(1);
        if (out_ready) j++;
      end
      if (done_valid) begin
        if (exp_n == 0 && mode == 0) check("zero-beat done timing", c, 3);
        check("done_count", done_count, 64'(exp_n));
        check("beats received", j, exp_n);
        fin = 1;
      end
    end
    if (!fin) check("done timeout", 0, 1);
    @(negedge clk);
    check("done one cycle", done_valid, 0);
    check("query_ready after done", query_ready, 1);
    check("out_valid after done", out_valid, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    bit saw_done;
    bit got_valid;
    vecs[0]  = '{k: 5'd0,  th: 32'd0,   n: 10, mode: 0};
    vecs[1]  = '{k: 5'd3,  th: 32'd0,   n: 3,  mode: 0};
    vecs[2]  = '{k: 5'd31, th: 32'd0,   n: 10, mode: 0};
    vecs[3]  = '{k: 5'd0,  th: 32'd55,  n: 5,  mode: 0};
    vecs[4]  = '{k: 5'd0,  th: 32'd200, n: 0,  mode: 0};
    vecs[5]  = '{k: 5'd25, th: 32'd0,   n: 10, mode: 0};
    vecs[6]  = '{k: 5'd0,  th: 32'd100, n: 1,  mode: 0};
    vecs[7]  = '{k: 5'd0,  th: 32'd11,  n: 9,  mode: 0};
    vecs[8]  = '{k: 5'd1,  th: 32'd10,  n: 1,  mode: 0};
    vecs[9]  = '{k: 5'd0,  th: 32'd0,   n: 10, mode: 1};
    vecs[10] = '{k: 5'd0,  th: 32'd55,  n: 5,  mode: 2};
    vecs[11] = '{k: 5'd8,  th: 32'd0,   n: 8,  mode: 3};

    load_table(0);
    #2;
    check("reset query_ready", query_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset done_valid", done_valid, 0);
    check("reset busy", busy, 0);
    check("reset out_cnt", out_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 12; v++) begin
      run_query(vecs[v].k, vecs[v].th, vecs[v].n, vecs[v].mode);
    end

    // Reset after two accepted beats aborts the report without a done pulse.
    @(negedge clk);
    query_top_k = '0; query_thresh = '0; query_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    query_valid = 1'b0;
    got_valid = 0;
    for (int t = 0; t < 10 && !got_valid; t++) begin
      @(negedge clk);
      got_valid = out_valid;
    end
    check("reset test stream started", got_valid, 1);
    repeat (2) @(negedge clk);
    check("rank before reset", out_rank, 2);
    rst = 1'b1;
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst query_ready", query_ready, 1);
    check("rst busy", busy, 0);
    saw_done = done_valid;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      saw_done = saw_done | done_valid;
    end
    check("no done after reset", saw_done, 0);
    run_query(5'd0, 32'd0, 10, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
